// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: sequencer states, FPU opcodes
// and a few float32 bit patterns.
package fft_pkg;

  // Sequencer state encoding for the complex-multiply schedule.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_M0   = 3'd1,
    ST_M1   = 3'd2,
    ST_M2   = 3'd3,
    ST_M3   = 3'd4,
    ST_S0   = 3'd5,
    ST_S1   = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  // FPU opcodes: bit1 selects the adder, bit0 selects subtract, bit2 unused.
  localparam logic [2:0] FPU_OP_MUL = 3'b000;
  localparam logic [2:0] FPU_OP_ADD = 3'b010;
  localparam logic [2:0] FPU_OP_SUB = 3'b011;

  // Common float32 bit patterns.
  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

  // Negate a float32 by flipping only its sign bit (+0 becomes -0).
  function automatic logic [31:0] fp_neg(input logic [31:0] x);
    return {~x[31], x[30:0]};
  endfunction

endpackage

// File: rtl/fpu_cmul_seq.sv
// Complex multiply sequencer: P = A x B (or A x conj(B)) computed with four
// multiplies and two add/sub operations on one external, time-shared FPU.
module fpu_cmul_seq
  import fft_pkg::*;
#(
  parameter int OP_WAIT = 0,    // extra hold cycles per FPU operation, 0..7
  parameter bit CONJ_B  = 1'b0  // 1: use conj(B) (inverse FFT)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_re,
  input  logic [31:0] a_im,
  input  logic [31:0] b_re,
  input  logic [31:0] b_im,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] p_re,
  output logic [31:0] p_im,
  output logic [31:0] fpu_in1,
  output logic [31:0] fpu_in2,
  output logic        fpu_en,
  output logic [2:0]  fpu_opcode,
  input  logic [31:0] fpu_out
);

  state_t      state_reg, state_next;
  logic [2:0]  wait_cnt_reg;
  logic        step_done;
  logic [31:0] a_re_reg, a_im_reg, b_re_reg, b_im_reg;
  logic [31:0] t0_reg, t1_reg, t2_reg, t3_reg;

  // The FPU result is taken on the last cycle of each operation.
  assign step_done = (wait_cnt_reg == 3'(OP_WAIT));

  // Next-state and FPU drive: operands/opcode come straight from registers.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    fpu_en     = 1'b0;
    fpu_opcode = FPU_OP_MUL;
    fpu_in1    = FP_ZERO;
    fpu_in2    = FP_ZERO;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = ST_M0;
      end
      ST_M0: begin
        fpu_en  = 1'b1;
        fpu_in1 = a_re_reg;
        fpu_in2 = b_re_reg;
        if (step_done) state_next = ST_M1;
      end
      ST_M1: begin
        fpu_en  = 1'b1;
        fpu_in1 = a_im_reg;
        fpu_in2 = b_im_reg;
        if (step_done) state_next = ST_M2;
      end
      ST_M2: begin
        fpu_en  = 1'b1;
        fpu_in1 = a_re_reg;
        fpu_in2 = b_im_reg;
        if (step_done) state_next = ST_M3;
      end
      ST_M3: begin
        fpu_en  = 1'b1;
        fpu_in1 = a_im_reg;
        fpu_in2 = b_re_reg;
        if (step_done) state_next = ST_S0;
      end
      ST_S0: begin
        fpu_en     = 1'b1;
        fpu_opcode = FPU_OP_SUB;
        fpu_in1    = t0_reg;
        fpu_in2    = t1_reg;
        if (step_done) state_next = ST_S1;
      end
      ST_S1: begin
        fpu_en     = 1'b1;
        fpu_opcode = FPU_OP_ADD;
        fpu_in1    = t2_reg;
        fpu_in2    = t3_reg;
        if (step_done) state_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Operand latch, wait counter and capture of each FPU result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_reg <= 3'd0;
      a_re_reg     <= FP_ZERO;
      a_im_reg     <= FP_ZERO;
      b_re_reg     <= FP_ZERO;
      b_im_reg     <= FP_ZERO;
      t0_reg       <= FP_ZERO;
      t1_reg       <= FP_ZERO;
      t2_reg       <= FP_ZERO;
      t3_reg       <= FP_ZERO;
      p_re         <= FP_ZERO;
      p_im         <= FP_ZERO;
    end else begin
      if (state_reg == ST_IDLE && in_valid) begin
        a_re_reg <= a_re;
        a_im_reg <= a_im;
        b_re_reg <= b_re;
        b_im_reg <= CONJ_B ? fp_neg(b_im) : b_im;
      end
      if (fpu_en) begin
        if (step_done) begin
          wait_cnt_reg <= 3'd0;
          case (state_reg)
            ST_M0:   t0_reg <= fpu_out;
            ST_M1:   t1_reg <= fpu_out;
            ST_M2:   t2_reg <= fpu_out;
            ST_M3:   t3_reg <= fpu_out;
            ST_S0:   p_re   <= fpu_out;
            ST_S1:   p_im   <= fpu_out;
            default: ;
          endcase
        end else begin
          wait_cnt_reg <= wait_cnt_reg + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpu_cmul_seq.sv
// Bench for fpu_cmul_seq: three instances (plain, conj(B), OP_WAIT=2), each
// with an integer-valued FPU model; products checked against a complex
// multiply reference computed directly from integer operands.
module tb_fpu_cmul_seq;
  import fft_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid_s  [N];
  logic        out_ready_s [N];
  logic [31:0] a_re_s [N];
  logic [31:0] a_im_s [N];
  logic [31:0] b_re_s [N];
  logic [31:0] b_im_s [N];
  wire         in_ready_s  [N];
  wire         out_valid_s [N];
  wire         fpu_en_s    [N];
  wire  [2:0]  fpu_op_s    [N];
  wire  [31:0] p_re_s    [N];
  wire  [31:0] p_im_s    [N];
  wire  [31:0] fpu_in1_s [N];
  wire  [31:0] fpu_in2_s [N];
  wire  [31:0] fpu_out_s [N];

  int tests_run = 0;
  int tests_failed = 0;

  logic [2:0]  tr_op  [$];
  logic [31:0] tr_in1 [$];
  logic [31:0] tr_in2 [$];

  always #5 clk = ~clk;

  // Exact float32 encoding of a small integer.
  function automatic logic [31:0] int_to_f32(input int v);
    int mag;
    int p;
    logic [31:0] r;
    r = 32'h0;
    if (v == 0) return r;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((mag << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  // Integer value of a float32 holding an integer (either zero sign -> 0).
  function automatic int f32_to_int(input logic [31:0] f);
    int e;
    int mag;
    e = int'(f[30:23]);
    if (e == 0) return 0;
    mag = int'({8'h01, f[22:0]}) >> (150 - e);
    return f[31] ? -mag : mag;
  endfunction

  // FPU stand-in: combinational, output 0 when disabled.
  function automatic logic [31:0] fpu_model(input logic en, input logic [2:0] op,
                                            input logic [31:0] x, input logic [31:0] y);
    int a;
    int b;
    a = f32_to_int(x);
    b = f32_to_int(y);
    if (!en) return 32'h0;
    if (!op[1]) return int_to_f32(a * b);
    if (op[0]) return int_to_f32(a - b);
    return int_to_f32(a + b);
  endfunction

  // Reference complex product, instance 1 uses conj(B).
  function automatic logic [31:0] ref_re(input int d, input int ar, input int ai,
                                         input int br, input int bi);
    int be;
    be = (d == 1) ? -bi : bi;
    return int_to_f32(ar * br - ai * be);
  endfunction

  function automatic logic [31:0] ref_im(input int d, input int ar, input int ai,
                                         input int br, input int bi);
    int be;
    be = (d == 1) ? -bi : bi;
    return int_to_f32(ar * be + ai * br);
  endfunction

  function automatic int ref_lat(input int d);
    return (d == 2) ? 18 : 6;
  endfunction

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dut
      fpu_cmul_seq #(
        .OP_WAIT(gi == 2 ? 2 : 0),
        .CONJ_B (gi == 1 ? 1'b1 : 1'b0)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_s[gi]),
        .in_ready  (in_ready_s[gi]),
        .a_re      (a_re_s[gi]),
        .a_im      (a_im_s[gi]),
        .b_re      (b_re_s[gi]),
        .b_im      (b_im_s[gi]),
        .out_valid (out_valid_s[gi]),
        .out_ready (out_ready_s[gi]),
        .p_re      (p_re_s[gi]),
        .p_im      (p_im_s[gi]),
        .fpu_in1   (fpu_in1_s[gi]),
        .fpu_in2   (fpu_in2_s[gi]),
        .fpu_en    (fpu_en_s[gi]),
        .fpu_opcode(fpu_op_s[gi]),
        .fpu_out   (fpu_out_s[gi])
      );
      assign fpu_out_s[gi] = fpu_model(fpu_en_s[gi], fpu_op_s[gi], fpu_in1_s[gi], fpu_in2_s[gi]);
    end
  endgenerate

  // One operand set through instance d; lat counts edges after the accept edge.
  task automatic run_op(input int d, input int ar, input int ai, input int br, input int bi,
                        input bit release_out, output logic [31:0] pre,
                        output logic [31:0] pim, output int lat);
    int guard;
    tr_op.delete();
    tr_in1.delete();
    tr_in2.delete();
    a_re_s[d] = int_to_f32(ar);
    a_im_s[d] = int_to_f32(ai);
    b_re_s[d] = int_to_f32(br);
    b_im_s[d] = int_to_f32(bi);
    in_valid_s[d] = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready_s[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    in_valid_s[d] = 1'b0;
    a_re_s[d] = $urandom();
    a_im_s[d] = $urandom();
    b_re_s[d] = $urandom();
    b_im_s[d] = $urandom();
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (fpu_en_s[d]) begin
        tr_op.push_back(fpu_op_s[d]);
        tr_in1.push_back(fpu_in1_s[d]);
        tr_in2.push_back(fpu_in2_s[d]);
      end
      if (out_valid_s[d]) break;
      if (lat >= 100) begin
        lat = -1;
        break;
      end
      @(posedge clk);
      lat++;
    end
    pre = p_re_s[d];
    pim = p_im_s[d];
    $display("[TB] dut%0d A=(%0d,%0d) B=(%0d,%0d) -> p=(%08h,%08h) latency=%0d",
             d, ar, ai, br, bi, pre, pim, lat);
    if (release_out) begin
      out_ready_s[d] = 1'b1;
      @(posedge clk);
      #1;
      out_ready_s[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < N; d++) begin
      tests_run++;
      if (in_ready_s[d] !== 1'b1 || out_valid_s[d] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hs dut%0d: in_ready=%b out_valid=%b, required 1/0",
                 d, in_ready_s[d], out_valid_s[d]);
      end
      tests_run++;
      if (p_re_s[d] !== 32'h0 || p_im_s[d] !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_p dut%0d: p=(%h,%h), required (0,0)", d, p_re_s[d], p_im_s[d]);
      end
      tests_run++;
      if (fpu_en_s[d] !== 1'b0 || fpu_op_s[d] !== 3'b000 ||
          fpu_in1_s[d] !== 32'h0 || fpu_in2_s[d] !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_fpu dut%0d: en=%b op=%b in1=%h in2=%h, required all 0",
                 d, fpu_en_s[d], fpu_op_s[d], fpu_in1_s[d], fpu_in2_s[d]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [31:0] pre, pim;
    int lat;
    logic [2:0] exp_op [6];
    int e1 [6];
    int e2 [6];
    exp_op = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b010};
    e1 = '{1, 2, 1, 2, 3, 4};
    e2 = '{3, 4, 4, 3, 8, 6};
    run_op(0, 1, 2, 3, 4, 1'b1, pre, pim, lat);
    tests_run++;
    if (pre !== 32'hC0A0_0000 || pim !== 32'h4120_0000) begin
      tests_failed++;
      $display("FAIL directed_p: got (%h,%h), required (c0a00000,41200000)", pre, pim);
    end
    tests_run++;
    if (lat !== 6) begin
      tests_failed++;
      $display("FAIL directed_latency: got %0d, required 6", lat);
    end
    tests_run++;
    if (tr_op.size() !== 6) begin
      tests_failed++;
      $display("FAIL directed_steps: got %0d enabled cycles, required 6", tr_op.size());
    end
    for (int i = 0; i < 6 && i < tr_op.size(); i++) begin
      tests_run++;
      if (tr_op[i] !== exp_op[i] || tr_in1[i] !== int_to_f32(e1[i]) ||
          tr_in2[i] !== int_to_f32(e2[i])) begin
        tests_failed++;
        $display("FAIL directed_step%0d: got op=%b in1=%h in2=%h, required op=%b in1=%h in2=%h",
                 i, tr_op[i], tr_in1[i], tr_in2[i], exp_op[i], int_to_f32(e1[i]), int_to_f32(e2[i]));
      end
    end
    // Twiddle -j
    run_op(0, 1, 2, 0, -1, 1'b1, pre, pim, lat);
    tests_run++;
    if (pre !== 32'h4000_0000 || pim !== 32'hBF80_0000) begin
      tests_failed++;
      $display("FAIL twiddle_j: got (%h,%h), required (40000000,bf800000)", pre, pim);
    end
  endtask

  task automatic test_conj();
    logic [31:0] pre, pim;
    int lat;
    run_op(1, 1, 2, 3, 4, 1'b1, pre, pim, lat);
    tests_run++;
    if (pre !== 32'h4130_0000 || pim !== 32'h4000_0000 || lat !== 6) begin
      tests_failed++;
      $display("FAIL conj_p: got (%h,%h) lat %0d, required (41300000,40000000) lat 6", pre, pim, lat);
    end
    run_op(1, 1, 2, 3, 0, 1'b1, pre, pim, lat);
    tests_run++;
    if (tr_in2.size() < 2 || tr_in2[1] !== 32'h8000_0000) begin
      tests_failed++;
      $display("FAIL conj_zero_flip: got %h in M1 operand, required 80000000",
               (tr_in2.size() < 2) ? 32'hx : tr_in2[1]);
    end
    tests_run++;
    if (pre !== int_to_f32(3) || pim !== int_to_f32(6)) begin
      tests_failed++;
      $display("FAIL conj_zero_p: got (%h,%h), required (%h,%h)", pre, pim, int_to_f32(3), int_to_f32(6));
    end
  endtask

  task automatic test_op_wait();
    logic [31:0] pre, pim;
    int lat;
    logic [2:0] exp_op [6];
    int e1 [6];
    exp_op = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b011, 3'b010};
    e1 = '{1, 2, 1, 2, 3, 4};
    run_op(2, 1, 2, 3, 4, 1'b1, pre, pim, lat);
    tests_run++;
    if (pre !== 32'hC0A0_0000 || pim !== 32'h4120_0000 || lat !== 18) begin
      tests_failed++;
      $display("FAIL opwait_p: got (%h,%h) lat %0d, required (c0a00000,41200000) lat 18", pre, pim, lat);
    end
    tests_run++;
    if (tr_op.size() !== 18) begin
      tests_failed++;
      $display("FAIL opwait_steps: got %0d enabled cycles, required 18", tr_op.size());
    end
    for (int i = 0; i < 18 && i < tr_op.size(); i++) begin
      tests_run++;
      if (tr_op[i] !== exp_op[i / 3] || tr_in1[i] !== int_to_f32(e1[i / 3])) begin
        tests_failed++;
        $display("FAIL opwait_hold%0d: got op=%b in1=%h, required op=%b in1=%h",
                 i, tr_op[i], tr_in1[i], exp_op[i / 3], int_to_f32(e1[i / 3]));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] pre, pim;
    int lat;
    run_op(0, 2, -3, 5, 7, 1'b0, pre, pim, lat);
    tests_run++;
    if (pre !== ref_re(0, 2, -3, 5, 7) || pim !== ref_im(0, 2, -3, 5, 7)) begin
      tests_failed++;
      $display("FAIL bp_first: got (%h,%h), required (%h,%h)",
               pre, pim, ref_re(0, 2, -3, 5, 7), ref_im(0, 2, -3, 5, 7));
    end
    a_re_s[0] = int_to_f32(-4);
    a_im_s[0] = int_to_f32(1);
    b_re_s[0] = int_to_f32(6);
    b_im_s[0] = int_to_f32(-2);
    in_valid_s[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (in_ready_s[0] !== 1'b0 || out_valid_s[0] !== 1'b1 ||
          p_re_s[0] !== pre || p_im_s[0] !== pim) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: in_ready=%b out_valid=%b p=(%h,%h), required 0/1 (%h,%h)",
                 c, in_ready_s[0], out_valid_s[0], p_re_s[0], p_im_s[0], pre, pim);
      end
    end
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
    tests_run++;
    if (in_ready_s[0] !== 1'b1 || out_valid_s[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1/0", in_ready_s[0], out_valid_s[0]);
    end
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    tests_run++;
    if (in_ready_s[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_accept: in_ready=%b after accept edge, required 0", in_ready_s[0]);
    end
    lat = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid_s[0] || lat >= 100) break;
      @(posedge clk);
      lat++;
    end
    $display("[TB] dut0 A=(-4,1) B=(6,-2) -> p=(%08h,%08h) latency=%0d", p_re_s[0], p_im_s[0], lat);
    tests_run++;
    if (lat !== 6 || p_re_s[0] !== ref_re(0, -4, 1, 6, -2) || p_im_s[0] !== ref_im(0, -4, 1, 6, -2)) begin
      tests_failed++;
      $display("FAIL bp_second: got (%h,%h) lat %0d, required (%h,%h) lat 6", p_re_s[0], p_im_s[0],
               lat, ref_re(0, -4, 1, 6, -2), ref_im(0, -4, 1, 6, -2));
    end
    out_ready_s[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready_s[0] = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] pre, pim;
    int lat;
    a_re_s[0] = FP_ONE;
    a_im_s[0] = int_to_f32(5);
    b_re_s[0] = int_to_f32(7);
    b_im_s[0] = int_to_f32(4);
    in_valid_s[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid_s[0] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (fpu_en_s[0] !== 1'b1 || fpu_in1_s[0] !== FP_ONE || fpu_in2_s[0] !== int_to_f32(4)) begin
      tests_failed++;
      $display("FAIL midrst_m2: en=%b in1=%h in2=%h, required 1 %h %h",
               fpu_en_s[0], fpu_in1_s[0], fpu_in2_s[0], FP_ONE, int_to_f32(4));
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid_s[0] !== 1'b0 || in_ready_s[0] !== 1'b1 || fpu_en_s[0] !== 1'b0 ||
        p_re_s[0] !== 32'h0 || p_im_s[0] !== 32'h0) begin
      tests_failed++;
      $display("FAIL midrst_async: out_valid=%b in_ready=%b en=%b p=(%h,%h), required 0 1 0 (0,0)",
               out_valid_s[0], in_ready_s[0], fpu_en_s[0], p_re_s[0], p_im_s[0]);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid_s[0] !== 1'b0 || fpu_en_s[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_after: out_valid=%b en=%b, required 0/0", out_valid_s[0], fpu_en_s[0]);
    end
    run_op(0, 1, 2, 3, 4, 1'b1, pre, pim, lat);
    tests_run++;
    if (pre !== 32'hC0A0_0000 || pim !== 32'h4120_0000 || lat !== 6) begin
      tests_failed++;
      $display("FAIL midrst_next: got (%h,%h) lat %0d, required (c0a00000,41200000) lat 6", pre, pim, lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] pre, pim;
    int lat;
    int ar, ai, br, bi;
    for (int d = 0; d < N; d++) begin
      for (int k = 0; k < 8; k++) begin
        ar = int'($urandom_range(32, 0)) - 16;
        ai = int'($urandom_range(32, 0)) - 16;
        br = int'($urandom_range(32, 0)) - 16;
        bi = int'($urandom_range(32, 0)) - 16;
        run_op(d, ar, ai, br, bi, 1'b1, pre, pim, lat);
        tests_run++;
        if (pre !== ref_re(d, ar, ai, br, bi) || pim !== ref_im(d, ar, ai, br, bi) ||
            lat !== ref_lat(d)) begin
          tests_failed++;
          $display("FAIL random dut%0d #%0d: got (%h,%h) lat %0d, required (%h,%h) lat %0d",
                   d, k, pre, pim, lat, ref_re(d, ar, ai, br, bi), ref_im(d, ar, ai, br, bi), ref_lat(d));
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < N; d++) begin
      in_valid_s[d]  = 1'b0;
      out_ready_s[d] = 1'b0;
      a_re_s[d] = 32'h0;
      a_im_s[d] = 32'h0;
      b_re_s[d] = 32'h0;
      b_im_s[d] = 32'h0;
    end
    test_reset();
    test_directed();
    test_conj();
    test_op_wait();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
